// File: rtl/tt_response_checker.sv
// Truth-table response checker: samples DUT output SETTLE+1 cycles after each
// vector strobe, compares against EXPECTED, tracks coverage/errors/first failure.
module tt_response_checker #(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = '0,
  parameter int                      SETTLE   = 2,
  parameter int                      ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              vec_valid,
  input  logic [N_IN-1:0]   vec,
  input  logic              y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail,
  output logic              overrun
);
  localparam int         DEPTH    = 1 << N_IN;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SETL, CHECK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [N_IN-1:0]   vec_q, vec_nxt;
  logic [DEPTH-1:0]  cov;
  logic              chk, ovr_set, mism;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec_q;
    chk       = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: if (vec_valid) begin
        vec_nxt   = vec;
        cnt_nxt   = CNT_LOAD;
        state_nxt = SETL;
      end
      SETL: begin
        // A new strobe abandons the pending vector and restarts the settle window.
        if (vec_valid) begin
          vec_nxt = vec;
          cnt_nxt = CNT_LOAD;
          ovr_set = 1'b1;
        end else if (cnt == 4'd0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CHECK: begin
        chk = 1'b1;
        if (vec_valid) begin
          vec_nxt   = vec;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SETL;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mism = (y != EXPECTED[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vec_q <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      vec_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vec_q <= vec_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov              <= '0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail       <= '0;
      overrun          <= 1'b0;
    end else if (clear) begin
      cov              <= '0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail       <= '0;
      overrun          <= 1'b0;
    end else begin
      // done trails the coverage update by one cycle and is sticky.
      done <= done | (&cov);
      if (ovr_set) overrun <= 1'b1;
      if (chk) begin
        cov[vec_q] <= 1'b1;
        if (mism) begin
          if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail       <= vec_q;
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: directed runs, a vector table, and a random
// run checked against a due-time transaction model.
module tb_tt_response_checker;
  localparam int SETTLE = 2;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, vec_valid = 1'b0, y = 1'b0;
  logic [3:0] vec = '0;
  logic busy, done, pass, ffv, ovr;
  logic [7:0] err;
  logic [3:0] ff;
  logic busy2, done2, pass2, ffv2, ovr2;
  logic [1:0] err2;
  logic [3:0] ff2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tt_response_checker #(.N_IN(4), .EXPECTED(16'h6996), .SETTLE(SETTLE), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .vec_valid(vec_valid), .vec(vec), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail(ff), .overrun(ovr));

  // Inverted table: every response of a correct DUT is a mismatch here.
  tt_response_checker #(.N_IN(4), .EXPECTED(16'h9669), .SETTLE(SETTLE), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .vec_valid(vec_valid), .vec(vec), .y(y),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail(ff2), .overrun(ovr2));

  // Transaction model: a strobe at edge c is compared at edge c+SETTLE+1 unless replaced.
  int        cyc = 0;
  bit        m_pend, m_ffv, m_ovr, m_done;
  int        m_due, m_err;
  bit [3:0]  m_pv, m_ff;
  bit [15:0] m_cov;

  task automatic model_clear();
    m_pend = 0; m_ffv = 0; m_ovr = 0; m_done = 0;
    m_due = 0; m_err = 0; m_pv = 0; m_ff = 0; m_cov = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit c, input bit vv, input logic [3:0] v, input bit yy);
    bit full;
    clear = c; vec_valid = vv; vec = v; y = yy;
    @(posedge clk);
    cyc++;
    if (c) model_clear();
    else begin
      full = (m_cov == 16'hFFFF);
      if (m_pend && cyc == m_due) begin
        if (yy != ^m_pv) begin
          if (m_err < 255) m_err++;
          if (!m_ffv) begin m_ffv = 1; m_ff = m_pv; end
        end
        m_cov[m_pv] = 1;
        m_pend = 0;
      end
      m_done = m_done | full;
      if (vv) begin
        if (m_pend) m_ovr = 1;
        m_pend = 1; m_pv = v; m_due = cyc + SETTLE + 1;
      end
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".ffv"}, ffv, 0);
    chk({tag, ".ff"}, ff, 0);
    chk({tag, ".ovr"}, ovr, 0);
  endtask

  // Strobe vectors 0..last in order, 20 cycles apart; wrong bits flip y.
  task automatic run_seq(input logic [15:0] wrong, input int last);
    for (int v = 0; v <= last; v++) begin
      tick(0, 1, 4'(v), (^4'(v)) ^ wrong[v]);
      for (int k = 0; k < 19; k++) tick(0, 0, 4'(v), (^4'(v)) ^ wrong[v]);
    end
  endtask

  typedef struct {
    bit vv; logic [3:0] v; bit yy;
    bit busy; bit ovr; logic [7:0] err; bit ffv; logic [3:0] ff;
  } row_t;
  row_t tbl[12];

  initial begin
    // vv  v   y   busy ovr err ffv ff
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 2, 1, 1, 0, 0, 0, 0};  // back-to-back in CHECK, vec 1 correct
    tbl[4]  = '{0, 2, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 2, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 2, 0, 0, 0, 1, 1, 2};  // vec 2 expects 1: mismatch
    tbl[7]  = '{1, 3, 0, 1, 0, 1, 1, 2};
    tbl[8]  = '{1, 7, 0, 1, 1, 1, 1, 2};  // overrun replaces vec 3
    tbl[9]  = '{0, 7, 1, 1, 1, 1, 1, 2};
    tbl[10] = '{0, 7, 1, 1, 1, 1, 1, 2};
    tbl[11] = '{0, 7, 1, 0, 1, 1, 1, 2};  // vec 7 correct

    model_clear();
    #12;
    chk_zero("reset");
    chk("reset.busy2", busy2, 0);
    chk("reset.err2", err2, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    chk_zero("idle");

    // Correct DUT over all vectors
    run_seq(16'h0000, 15);
    chk("A.done", done, 1);
    chk("A.pass", pass, 1);
    chk("A.err", err, 0);
    chk("A.ffv", ffv, 0);
    chk("A.ovr", ovr, 0);
    chk("A.err2_sat", err2, 3);
    chk("A.done2", done2, 1);
    chk("A.pass2", pass2, 0);

    // Wrong on 5 and 11
    tick(1, 0, 0, 0);
    chk_zero("clearA");
    run_seq(16'h0820, 15);
    chk("B.err", err, 2);
    chk("B.ff", ff, 5);
    chk("B.ffv", ffv, 1);
    chk("B.done", done, 1);
    chk("B.pass", pass, 0);

    // Coverage boundary: done 4 cycles after the last strobe
    tick(1, 0, 0, 0);
    run_seq(16'h0000, 14);
    chk("C.done14", done, 0);
    chk("C.pass14", pass, 0);
    tick(0, 1, 15, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, 15, 0);
      chk($sformatf("C.done_e%0d", k), done, (k == 4) ? 1 : 0);
    end
    chk("C.pass", pass, 1);

    // Table: back-to-back and overrun
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, tbl[i].vv, tbl[i].v, tbl[i].yy);
      chk($sformatf("T%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("T%0d.ovr", i), ovr, tbl[i].ovr);
      chk($sformatf("T%0d.err", i), err, tbl[i].err);
      chk($sformatf("T%0d.ffv", i), ffv, tbl[i].ffv);
      chk($sformatf("T%0d.ff", i), ff, tbl[i].ff);
    end
    // Cover every vector except 3 (7 is already covered): done must stay low
    for (int v = 0; v < 16; v++) if (v != 3) begin
      tick(0, 1, 4'(v), ^4'(v));
      for (int k = 0; k < 4; k++) tick(0, 0, 4'(v), ^4'(v));
    end
    chk("T.no3_done", done, 0);
    tick(0, 1, 3, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 3, 0);
    chk("T.with3_done", done, 1);

    // Async reset mid-SETTLE
    tick(0, 1, 6, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    tick(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
    chk("rst.err", err, 1);
    chk("rst.ff", ff, 1);
    chk("rst.ffv", ffv, 1);
    chk("rst.busy", busy, 0);
    chk("rst.ovr", ovr, 0);

    // clear beats vec_valid
    tick(0, 1, 4, 0);
    tick(1, 1, 9, 1);
    chk_zero("clr_vv");
    for (int k = 0; k < 4; k++) tick(0, 0, 9, 1);
    chk_zero("clr_after");

    // Randomized run against the model
    begin
      logic [3:0] applied;
      bit vv, e;
      logic [3:0] v;
      applied = 0;
      tick(1, 0, 0, 0);
      for (int n = 0; n < 4000; n++) begin
        vv = ($urandom % 3) == 0;
        v  = 4'($urandom);
        if (vv) applied = v;
        e  = ($urandom % 6) == 0;
        tick(0, vv, v, (^applied) ^ e);
        chk("R.busy", busy, m_pend);
        chk("R.err", err, m_err);
        chk("R.ffv", ffv, m_ffv);
        chk("R.ff", ff, m_ff);
        chk("R.ovr", ovr, m_ovr);
        chk("R.done", done, m_done);
        chk("R.pass", pass, m_done && m_err == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Hardware response checker for exhaustive truth-table runs on small combinational DUTs.
- The stimulus side walks all 2^N_IN input vectors. This block captures the DUT output for each vector after a settle time and compares it against an expected truth-table constant.
- It tracks vector coverage, mismatches and the first failing vector, then raises done/pass once every vector has been checked.
- It sits beside the DUT in lab/FPGA test harnesses, replacing waveform inspection.

Parameters:
- N_IN, 4, DUT input width; table depth is 2^N_IN.
- EXPECTED, 16'h0000, expected y per vector; bit i = y for vector value i; width 2^N_IN.
- SETTLE, 2, clock cycles from vec_valid to y sample, range 1..15.
- ERR_W, 8, err_count width; count saturates.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous: wipe coverage/errors/flags, go IDLE.
- vec_valid  in  1  one-cycle strobe: vec now applied to DUT.
- vec  in  N_IN  vector applied to DUT, valid with vec_valid.
- y  in  1  DUT output.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  sticky: all 2^N_IN vectors checked at least once.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  saturating mismatch count.
- first_fail_valid  out  1  sticky: a mismatch has occurred.
- first_fail  out  N_IN  vector of first mismatch.
- overrun  out  1  sticky: vec_valid arrived while SETTLE pending.

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0; coverage mask 0; settle counter 0; latched vector 0.
- States:
  - IDLE: on vec_valid, latch vec, load counter = SETTLE-1, go SETTLE.
  - SETTLE: counter decrements each cycle. At 0, go CHECK.
  - CHECK (1 cycle): sample y; compare to EXPECTED[latched vec].
    - Mismatch: err_count+1, saturating at 2^ERR_W-1. If first_fail_valid is 0, set it and load first_fail.
    - Set coverage bit [latched vec].
    - If vec_valid is also high this cycle, latch the new vec and go SETTLE (back-to-back). Otherwise go IDLE.
- Latency: y is sampled on the edge SETTLE+1 cycles after the edge that sees vec_valid. Results are visible on the following cycle.
- vec_valid during SETTLE: discard the pending vector (no compare, no coverage bit), latch the new vec, reload counter, set overrun.
- done sets the cycle after CHECK makes coverage all ones, then holds.
- After done, further vectors are still checked. Errors update err_count/pass; done stays 1.
- Repeated vector: compared again; errors count each time; coverage unchanged.
- pass is combinational from done and err_count; it drops if a later error occurs.
- clear has priority over vec_valid in the same cycle: all state is as at reset except the async path.
- Reset mid-SETTLE: pending sample abandoned, no compare.
- vec is latched only on accept, so vec may change freely at other times.
- y is assumed synchronous to clk; no synchronizer inside.

Test Plan:
- EXPECTED=16'h6996 (4-input XOR), SETTLE=2: correct DUT, 16 vectors in order, each strobe 20 cycles apart -> done=1, pass=1, err_count=0, first_fail_valid=0, overrun=0.
- Same run with y forced wrong on vectors 5 and 11 -> err_count=2, first_fail=4'd5, first_fail_valid=1, done=1, pass=0.
- Only vectors 0..14 applied -> done=0, pass=0; then apply 15 -> done=1 exactly 4 cycles after that strobe (SETTLE+1 to sample, +1 to flag).
- Strobe vec=3, then strobe vec=7 one cycle later -> overrun=1; vector 3 not covered, vector 7 covered; back-to-back strobe in CHECK cycle -> no overrun.
- ERR_W=2, all-wrong DUT over 16 vectors -> err_count saturates at 3.
- Assert rst_n low mid-SETTLE, and separately pulse clear with vec_valid high -> all outputs 0, busy=0, next strobe starts clean.
